// File: rtl/gpio_ctrl_if.sv
// rtl/gpio_ctrl_if.sv - memory-mapped register bus between the CPU IO decoder and gpio_ctrl
interface gpio_ctrl_if;
    logic        sel;
    logic        write_en;
    logic        read_en;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output sel,
        output write_en,
        output read_en,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  sel,
        input  write_en,
        input  read_en,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - GPIO controller with direction, synchronised inputs, set/clr/toggle and edge interrupts
module gpio_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    gpio_ctrl_if.slave       bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [3:0] ADDR_OUT     = 4'h0;
    localparam logic [3:0] ADDR_DIR     = 4'h1;
    localparam logic [3:0] ADDR_IN      = 4'h2;
    localparam logic [3:0] ADDR_SET     = 4'h3;
    localparam logic [3:0] ADDR_CLR     = 4'h4;
    localparam logic [3:0] ADDR_TGL     = 4'h5;
    localparam logic [3:0] ADDR_RISE_EN = 4'h6;
    localparam logic [3:0] ADDR_FALL_EN = 4'h7;
    localparam logic [3:0] ADDR_STATUS  = 4'h8;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] in_prev;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] rise, fall, w1c_mask;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd_val;
    logic             wr;

    // Data bits above WIDTH are architecturally ignored on writes.
    logic unused_wdata;
    assign unused_wdata = ^bus.wdata;

    assign wr      = bus.sel && bus.write_en;
    assign wd      = bus.wdata[WIDTH-1:0];
    assign in_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            in_prev <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            in_prev <= in_sync;
        end
    end

    always_comb begin
        out_d = out_q;
        if (wr) begin
            case (bus.addr)
                ADDR_OUT: out_d = wd;
                ADDR_SET: out_d = out_q | wd;
                ADDR_CLR: out_d = out_q & ~wd;
                ADDR_TGL: out_d = out_q ^ wd;
                default:  out_d = out_q;
            endcase
        end
    end

    // A fresh edge in the same cycle as its write-1-to-clear keeps the bit set.
    always_comb begin
        rise     = in_sync & ~in_prev;
        fall     = ~in_sync & in_prev;
        w1c_mask = (wr && bus.addr == ADDR_STATUS) ? wd : '0;
        status_d = (status_q & ~w1c_mask) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
        end else begin
            out_q    <= out_d;
            status_q <= status_d;
            if (wr && bus.addr == ADDR_DIR)     dir_q     <= wd;
            if (wr && bus.addr == ADDR_RISE_EN) rise_en_q <= wd;
            if (wr && bus.addr == ADDR_FALL_EN) fall_en_q <= wd;
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus.addr)
            ADDR_OUT:     rd_val = out_q;
            ADDR_DIR:     rd_val = dir_q;
            ADDR_IN:      rd_val = in_sync;
            ADDR_RISE_EN: rd_val = rise_en_q;
            ADDR_FALL_EN: rd_val = fall_en_q;
            ADDR_STATUS:  rd_val = status_q;
            default:      rd_val = '0;
        endcase
        bus.rdata = '0;
        if (bus.sel && bus.read_en) bus.rdata[WIDTH-1:0] = rd_val;
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |status_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - directed and randomized checks of gpio_ctrl against a queue-based pin model
module tb_gpio_ctrl;
    localparam int WIDTH = 8;
    localparam int SS    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq;

    gpio_ctrl_if bus ();

    gpio_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] m_out, m_dir, m_ren, m_fen, m_stat, m_prev, m_sync;
    logic [WIDTH-1:0] m_pins [$];
    logic [WIDTH-1:0] pins;
    logic [31:0]      last_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_out = '0; m_dir = '0; m_ren = '0; m_fen = '0;
        m_stat = '0; m_prev = '0; m_sync = '0;
        m_pins.delete();
        for (int i = 0; i < SS; i++) m_pins.push_back('0);
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a)
            4'h0:    return {24'b0, m_out};
            4'h1:    return {24'b0, m_dir};
            4'h2:    return {24'b0, m_sync};
            4'h6:    return {24'b0, m_ren};
            4'h7:    return {24'b0, m_fen};
            4'h8:    return {24'b0, m_stat};
            default: return 32'h0;
        endcase
    endfunction

    // The synchronised value is simply the pin as sampled SS-1 edges before the latest one.
    function automatic void model_edge(input logic s, input logic w, input logic [3:0] a,
                                       input logic [31:0] d, input logic [WIDTH-1:0] pin);
        logic [WIDTH-1:0] rise, fall, clr, dv;
        dv   = d[WIDTH-1:0];
        rise = m_sync & ~m_prev;
        fall = ~m_sync & m_prev;
        clr  = (s && w && a == 4'h8) ? dv : '0;
        m_stat = (m_stat & ~clr) | (rise & m_ren) | (fall & m_fen);
        m_prev = m_sync;
        m_pins.push_back(pin);
        void'(m_pins.pop_front());
        m_sync = m_pins[0];
        if (s && w) begin
            case (a)
                4'h0: m_out = dv;
                4'h1: m_dir = dv;
                4'h3: m_out = m_out | dv;
                4'h4: m_out = m_out & ~dv;
                4'h5: m_out = m_out ^ dv;
                4'h6: m_ren = dv;
                4'h7: m_fen = dv;
                default: ;
            endcase
        end
    endfunction

    task automatic step(input logic s, input logic w, input logic r, input logic [3:0] a,
                        input logic [31:0] d, input logic [WIDTH-1:0] pin);
        @(negedge clk);
        bus.sel = s; bus.write_en = w; bus.read_en = r; bus.addr = a; bus.wdata = d;
        gpio_in = pin;
        #1;
        last_rdata = bus.rdata;
        check_eq($sformatf("rdata a=%0h", a), bus.rdata, (s && r) ? model_read(a) : 32'h0);
        @(posedge clk);
        model_edge(s, w, a, d, pin);
        #1;
        check_eq("gpio_out", {24'b0, gpio_out}, {24'b0, m_out});
        check_eq("gpio_oe",  {24'b0, gpio_oe},  {24'b0, m_dir});
        check_eq("irq",      {31'b0, irq},      {31'b0, |m_stat});
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, 1'b0, a, d, pins);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b1, 1'b0, 1'b1, a, 32'h0, pins);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, pins);
    endtask

    initial begin
        bus.sel = 1'b0; bus.write_en = 1'b0; bus.read_en = 1'b0;
        bus.addr = 4'h0; bus.wdata = 32'h0;
        gpio_in = '0; pins = '0; last_rdata = '0;
        model_reset();
        #1;
        check_eq("reset gpio_out", {24'b0, gpio_out}, 32'h0);
        check_eq("reset gpio_oe",  {24'b0, gpio_oe},  32'h0);
        check_eq("reset irq",      {31'b0, irq},      32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain register access and bits above WIDTH
        wr(4'h0, 32'hA5);
        wr(4'h1, 32'h0F);
        check_eq("out A5", {24'b0, gpio_out}, 32'hA5);
        check_eq("oe 0F",  {24'b0, gpio_oe},  32'h0F);
        rd(4'h0); check_eq("read OUT", last_rdata, 32'hA5);
        rd(4'h3); check_eq("read SET", last_rdata, 32'h0);
        wr(4'h3, 32'h0A); check_eq("set",    {24'b0, gpio_out}, 32'hAF);
        wr(4'h4, 32'hA0); check_eq("clr",    {24'b0, gpio_out}, 32'h0F);
        wr(4'h5, 32'hFF); check_eq("toggle", {24'b0, gpio_out}, 32'hF0);
        wr(4'h0, 32'hFFFF_FFFF);
        rd(4'h0); check_eq("read OUT wide", last_rdata, 32'hFF);
        wr(4'h2, 32'h55);
        rd(4'h2); check_eq("IN ignores write", last_rdata, 32'h0);

        // Rising edge on bit0 through the synchroniser
        wr(4'h6, 32'h01);
        pins = 8'h01;
        idle(2);
        check_eq("irq before edge3", {31'b0, irq}, 32'h0);
        rd(4'h2); check_eq("IN after 2 edges", last_rdata, 32'h01);
        check_eq("irq on edge3", {31'b0, irq}, 32'h1);
        rd(4'h8); check_eq("status rise", last_rdata, 32'h01);
        wr(4'h8, 32'h01);
        check_eq("irq cleared", {31'b0, irq}, 32'h0);
        rd(4'h8); check_eq("status cleared", last_rdata, 32'h0);

        // Falling-only enable on bit1, bit2 disabled
        wr(4'h6, 32'h0); wr(4'h7, 32'h02);
        pins = 8'h03; idle(3);
        pins = 8'h01; idle(3);
        pins = 8'h03; idle(3);
        rd(4'h8); check_eq("status fall", last_rdata, 32'h02);
        pins = 8'h07; idle(3);
        pins = 8'h03; idle(3);
        rd(4'h8); check_eq("status bit2 ignored", last_rdata, 32'h02);
        wr(4'h8, 32'hFF);

        // New rise coinciding with its own W1C
        wr(4'h7, 32'h0); wr(4'h6, 32'h01);
        pins = 8'h02; idle(3);
        pins = 8'h03; idle(3);
        pins = 8'h02; idle(3);
        pins = 8'h03; idle(2);
        wr(4'h8, 32'h01);
        check_eq("set wins irq", {31'b0, irq}, 32'h1);
        rd(4'h8); check_eq("set wins status", last_rdata, 32'h01);

        // Asynchronous reset mid-sequence
        wr(4'h0, 32'hFF); wr(4'h6, 32'h03); wr(4'h8, 32'hFF);
        pins = 8'h00; idle(3);
        pins = 8'h03; idle(3);
        rd(4'h8); check_eq("status pre-reset", last_rdata, 32'h03);
        @(posedge clk);
        #2;
        bus.sel = 1'b1; bus.read_en = 1'b1; bus.write_en = 1'b0; bus.addr = 4'h0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("async gpio_out", {24'b0, gpio_out}, 32'h0);
        check_eq("async gpio_oe",  {24'b0, gpio_oe},  32'h0);
        check_eq("async irq",      {31'b0, irq},      32'h0);
        check_eq("async rdata",    bus.rdata,         32'h0);
        pins = 8'h00; gpio_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        foreach (pins[i]) ;
        for (int a = 0; a < 9; a++) begin
            rd(a[3:0]);
            check_eq($sformatf("post-reset a=%0h", a), last_rdata, 32'h0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic       s, w, r;
            logic [3:0] a;
            if ($urandom_range(0, 3) == 0) pins = WIDTH'($urandom);
            s = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 1) == 1;
            a = ($urandom_range(0, 4) == 0) ? 4'h8 : 4'($urandom_range(0, 15));
            step(s, w, r, a, $urandom, pins);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
